// File: rtl/fp_stream_sink_fifo_pkg.sv
// Shared binary32 definitions for the FP filter, source and sink blocks.
package fp_stream_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

    // True for quiet or signalling NaN; infinities have a zero mantissa.
    function automatic logic fp_is_nan(input logic [FP_W-1:0] word);
        return (word[FP_W-2 -: EXP_W] == EXP_ALL_ONES) && (word[MAN_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/fp_stream_sink_fifo_if.sv
// Upstream valid-only stream plus downstream valid/ready output of the sink FIFO.
interface fp_stream_sink_fifo_if;
    import fp_stream_pkg::*;

    logic            valid_in;
    logic [FP_W-1:0] data_in;
    logic            m_valid;
    logic [FP_W-1:0] m_data;
    logic            m_ready;

    modport master (output valid_in, data_in, m_ready, input m_valid, m_data);
    modport slave  (input valid_in, data_in, m_ready, output m_valid, m_data);

endinterface

// File: rtl/fp_stream_sink_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, no reset on the array.
module fp_stream_fifo_mem
    import fp_stream_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [FP_W-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [FP_W-1:0] rdata_o
);

    logic [FP_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fp_stream_sink_fifo.sv
// Sink FIFO for the valid-only binary32 stream: buffers words, re-presents
// them first-word-fall-through on valid/ready and counts overflow drops.
// Optional macro FP_SINK_NAN_CHECK_EN builds the sticky NaN-input detector;
// without it nan_seen is tied low.
module fp_stream_sink_fifo
    import fp_stream_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    fp_stream_sink_fifo_if.slave s,
    input  logic               clear_err,
    output logic [AW:0]        level,
    output logic               overflow,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               nan_seen
);

    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic [FP_W-1:0]  rdata;
    logic             full, push, pop, drop;

    // Full is taken from the occupancy count, so pointers never need an extra wrap bit.
    assign full = (level_q == LVL_FULL);
    assign pop  = s.m_valid && s.m_ready;
    assign push = s.valid_in && (!full || pop);
    assign drop = s.valid_in && full && !pop;

    fp_stream_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (s.data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign s.m_valid = (level_q != '0);
    assign s.m_data  = s.m_valid ? rdata : '0;
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    // Next-state for pointers, occupancy and overflow bookkeeping; a drop in the clear cycle still counts.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        cnt_base   = clear_err ? '0 : drop_cnt_q;
        overflow_d = clear_err ? 1'b0 : overflow_q;
        drop_cnt_d = cnt_base;
        if (drop) begin
            overflow_d = 1'b1;
            if (cnt_base != CNT_MAX) begin
                drop_cnt_d = cnt_base + 1'b1;
            end
        end
    end

    // State registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef FP_SINK_NAN_CHECK_EN
    logic nan_seen_q, nan_seen_d;

    // Only accepted words are classified; dropped NaNs do not set the flag.
    always_comb begin
        nan_seen_d = clear_err ? 1'b0 : nan_seen_q;
        if (push && fp_is_nan(s.data_in)) begin
            nan_seen_d = 1'b1;
        end
    end

    // Sticky NaN flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_seen_q <= 1'b0;
        end else begin
            nan_seen_q <= nan_seen_d;
        end
    end

    assign nan_seen = nan_seen_q;
`else
    assign nan_seen = 1'b0;
`endif

endmodule
